crc8_frame_arbiter: RTL and testbench
=====================================

Name: crc8_frame_arbiter

Overview:
- Shares one CRC-8 engine (poly x^8+x^2+x+1 = 0x07, init 0x00, MSB-first, no reflection, no final XOR) between NUM_REQ byte-stream requesters.
- Round-robin grants one whole frame at a time and forwards its bytes to a single output stream. After the requester's last byte it appends the computed CRC byte.
- Sits between the per-channel packet sources and the serial/link transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_LEN, 256, maximum payload bytes per frame before forced termination (2..65535).
- IDX_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final payload byte of the requester's frame.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i].
- m_valid  out  1  output byte valid.
- m_data  out  8  output byte (payload or CRC).
- m_last  out  1  high only on the CRC byte.
- m_src  out  IDX_W  index of the requester owning the current frame.
- m_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.
- err_oflow  out  NUM_REQ  one-cycle pulse: frame of requester i was truncated at MAX_LEN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, crc=0x00, byte counter=0, grant=0, rr pointer=0.
  - All outputs 0.
  - Reset mid-frame abandons the frame; no CRC byte is emitted.
- FSM states: IDLE, DATA, CRC.
- IDLE:
  - m_valid=0, req_ready=0.
  - If any req_valid is high, the winner is the first set bit searching upward from the rr pointer, wrapping.
  - Register grant=winner, crc=0x00, count=0, then go to DATA on the next edge. Arbitration costs exactly one cycle.
- DATA (g = grant):
  - Combinational pass-through: m_valid=req_valid[g], m_data=req_data[g], m_last=0, req_ready[g]=m_ready. All other req_ready=0.
  - On each accepted byte: crc<=crc8_next(crc, byte), count<=count+1.
  - If the accepted byte has req_last[g]=1, go to CRC.
  - If count+1==MAX_LEN and req_last[g]=0: go to CRC and pulse err_oflow[g] for one cycle. The requester's following bytes start a new frame.
  - While req_valid[g]=0, stay in DATA. The grant is not revoked.
- CRC:
  - m_valid=1, m_data=crc, m_last=1, m_src=g, all req_ready=0.
  - On m_ready: rr pointer<=(g+1) mod NUM_REQ, state<=IDLE.
- Handshake rules:
  - Once m_valid is asserted, m_data, m_last and m_src stay stable until m_ready, provided the requester honours valid/data stability.
  - m_src equals grant in DATA and CRC.
- Output latency:
  - A payload byte appears combinationally in the same cycle as its req_valid.
  - The CRC byte appears in the cycle after the last payload byte is accepted.
  - Minimum frame cost is N+2 cycles (arb + N payload + CRC).
- Boundary conditions:
  - Single-byte frame is legal.
  - The rr pointer wraps from NUM_REQ-1 to 0.
  - Requests arriving while busy wait.
  - The requester just served gets lowest priority in the next arbitration.
  - The byte counter is 16-bit and saturates at MAX_LEN.

Decomposition:
- Package crc8_pkg:
  - CRC8_POLY=8'h07, CRC8_INIT=8'h00.
  - State enum {IDLE, DATA, CRC}.
  - Function crc8_next(crc[7:0], d[7:0]), parallel 8-bit update, shared with the existing CRC engine.
- Sub-module rr_arbiter (NUM_REQ), combinational: inputs req, pointer; output winner index and any. Instantiated once.

Test Plan:
- Requester 0 sends 03 00 01 02 (last on 02), m_ready=1 -> output 03 00 01 02 21, m_last only on 21, m_src=0, 6 cycles from first req_valid to IDLE.
- Requester 2 sends single byte 03 with last -> output 03 then 09 (m_last=1).
- All 4 requesters hold a 2-byte frame continuously from reset -> grant order 0,1,2,3,0; each frame followed by its correct CRC; busy drops for exactly one cycle between frames.
- m_ready toggled 1/0 every cycle during a frame -> m_data/m_last stable while stalled, req_ready mirrors m_ready, CRC unchanged (00 00 -> 00).
- MAX_LEN=4, requester 1 sends 6 bytes without last -> output 4 bytes + CRC, err_oflow[1] pulses once; the next frame from requester 1 carries the remaining 2 bytes after round-robin.
- rst_n asserted for one cycle mid-DATA -> outputs 0 immediately (async); after release no CRC byte is emitted and arbitration restarts from requester 0.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR)
// and the frame arbiter state encoding.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  // One whole byte per call; the loop unrolls into a flat XOR network.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_frame_arbiter_if.sv
// Requester-side byte streams and the single merged output stream of the CRC-8 frame arbiter.
interface crc8_frame_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  logic                 m_valid;
  logic [7:0]           m_data;
  logic                 m_last;
  logic [IDX_W-1:0]     m_src;
  logic                 m_ready;

  // The arbiter side.
  modport master (
    input  req_valid, req_data, req_last, m_ready,
    output req_ready, m_valid, m_data, m_last, m_src
  );

  // The requesters plus the downstream consumer.
  modport slave (
    output req_valid, req_data, req_last, m_ready,
    input  req_ready, m_valid, m_data, m_last, m_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  int idx;

  // NOTE: every output and temporary gets a default before the loop, so no path leaves
  // a value held over from a previous evaluation (which would infer a latch).
  always_comb begin
    winner = '0;
    idx    = 0;
    any    = |req;
    // Walk offsets from farthest to nearest so the nearest requester is the final assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(pointer) + k) % NUM_REQ;
      if (req[idx]) begin
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/crc8_frame_arbiter.sv
// Round-robin frame arbiter that shares one CRC-8 engine between NUM_REQ byte streams and
// appends the CRC byte after each granted frame.
module crc8_frame_arbiter
  import crc8_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  crc8_frame_arbiter_if.master     bus,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       err_oflow
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_LEN);

  state_t             state, state_n;
  logic [IDX_W-1:0]   grant, grant_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [7:0]         crc, crc_n;
  logic [15:0]        count, count_n;
  logic [NUM_REQ-1:0] oflow_n;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [7:0]         cur_byte;
  logic               cur_valid;
  logic               cur_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .pointer (rr_ptr),
    .winner  (winner),
    .any     (any_req)
  );

  assign cur_byte  = bus.req_data[{grant, 3'b000} +: 8];
  assign cur_valid = bus.req_valid[grant];
  assign cur_last  = bus.req_last[grant];

  assign bus.m_src = grant;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    rr_ptr_n      = rr_ptr;
    crc_n         = crc;
    count_n       = count;
    oflow_n       = '0;
    bus.m_valid   = 1'b0;
    bus.m_data    = '0;
    bus.m_last    = 1'b0;
    bus.req_ready = '0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_n = winner;
          crc_n   = CRC8_INIT;
          count_n = '0;
          state_n = DATA;
        end
      end

      DATA: begin
        bus.m_valid          = cur_valid;
        bus.m_data           = cur_byte;
        bus.req_ready[grant] = bus.m_ready;
        if (cur_valid && bus.m_ready) begin
          crc_n   = crc8_next(crc, cur_byte);
          count_n = (count == MAX_CNT) ? count : count + 16'd1;
          if (cur_last) begin
            state_n = CRC;
          end else if (count == MAX_CNT - 16'd1) begin
            // Truncated frame: close it with a CRC; the remaining bytes form a new frame later.
            state_n        = CRC;
            oflow_n[grant] = 1'b1;
          end
        end
      end

      CRC: begin
        bus.m_valid = 1'b1;
        bus.m_data  = crc;
        bus.m_last  = 1'b1;
        if (bus.m_ready) begin
          rr_ptr_n = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
          state_n  = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the simulator evaluates processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      crc       <= CRC8_INIT;
      count     <= '0;
      err_oflow <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_ptr_n;
      crc       <= crc_n;
      count     <= count_n;
      err_oflow <= oflow_n;
    end
  end

endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// Directed bench for crc8_frame_arbiter (MAX_LEN=4) with hand-computed CRC-8 values.
module tb_crc8_frame_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MAX_LEN = 4;
  localparam int IDX_W   = 2;

  logic clk;
  logic rst_n;
  logic busy;
  logic [NUM_REQ-1:0] err_oflow;

  crc8_frame_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  crc8_frame_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .err_oflow (err_oflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source bytes per requester: bit 8 = last, bits 7:0 = data.
  logic [8:0]  src_q[NUM_REQ][$];
  // Observed and expected output beats: {last, src[2:0], data}.
  logic [11:0] out_q[$];
  logic [11:0] exp_q[$];
  logic        busy_hist[$];
  int          oflow_cnt[NUM_REQ];
  int          last_cycles;

  logic        toggle_mode = 1'b0;
  logic        stall_chk   = 1'b0;
  logic        prev_stall  = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ob(input logic last, input int src, input logic [7:0] d);
    return {last, 3'(src), d};
  endfunction

  // Queue n bytes (given MSB-first in 'bytes') on requester r; optionally mark the final one last.
  task automatic push_frame(input int r, input int n, input logic [63:0] bytes, input logic last_on_end);
    for (int k = 0; k < n; k++) begin
      src_q[r].push_back({(last_on_end && k == n - 1), bytes[(n - 1 - k) * 8 +: 8]});
    end
  endtask

  task automatic exp_frame(input int src, input int n, input logic [63:0] bytes, input logic [7:0] crc);
    for (int k = 0; k < n; k++) exp_q.push_back(ob(1'b0, src, bytes[(n - 1 - k) * 8 +: 8]));
    exp_q.push_back(ob(1'b1, src, crc));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i * 8 +: 8] = src_q[i][0][7:0];
        bus.req_last[i]          = src_q[i][0][8];
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_data[i * 8 +: 8] = 8'h00;
        bus.req_last[i]          = 1'b0;
      end
    end
  endtask

  // One clock: drive after the rising edge, observe and retire handshakes on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    drive_inputs();
    bus.m_ready = toggle_mode ? ~bus.m_ready : 1'b1;
    @(negedge clk);
    if (stall_chk) begin
      if (prev_stall) begin
        check("stall_data", bus.m_data, prev_data);
        check("stall_last", bus.m_last, prev_last);
      end
      if (bus.m_valid && !bus.m_last)
        check("ready_mirror", bus.req_ready, {2'b00, bus.m_ready, 1'b0});
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
    if (bus.m_valid && bus.m_ready) out_q.push_back({bus.m_last, 3'(bus.m_src), bus.m_data});
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
      if (err_oflow[i]) oflow_cnt[i]++;
    end
    busy_hist.push_back(busy);
  endtask

  task automatic run_until(input string tag, input int n_out, input int budget);
    int c = 0;
    while (out_q.size() < n_out && c < budget) begin
      tick();
      c++;
    end
    last_cycles = c;
    check({tag, "_count"}, out_q.size(), n_out);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  task automatic start_test();
    out_q.delete();
    exp_q.delete();
    busy_hist.delete();
    for (int i = 0; i < NUM_REQ; i++) oflow_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.m_ready   = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, zeros, run, maxrun, first;

    do_reset();
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_data", bus.m_data, 8'h00);
    check("rst_m_last", bus.m_last, 1'b0);
    check("rst_m_src", bus.m_src, 2'd0);
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err_oflow", err_oflow, 4'b0000);

    // Requester 0: 03 00 01 02 -> CRC 21, six cycles from request to IDLE.
    start_test();
    push_frame(0, 4, 64'h03000102, 1'b1);
    exp_frame(0, 4, 64'h03000102, 8'h21);
    run_until("t1", 5, 30);
    check("t1_cycles", last_cycles, 6);
    tick();
    check("t1_idle_after", busy_hist[busy_hist.size() - 1], 1'b0);
    ones = 0;
    foreach (busy_hist[i]) if (busy_hist[i]) ones++;
    check("t1_busy_cycles", ones, 5);

    // Requester 2 single-byte frame: 03 -> CRC 09.
    start_test();
    push_frame(2, 1, 64'h03, 1'b1);
    exp_frame(2, 1, 64'h03, 8'h09);
    run_until("t2", 2, 20);

    // All requesters hold 2-byte frames from reset: order 0,1,2,3,0 with one idle cycle between.
    do_reset();
    start_test();
    push_frame(0, 2, 64'h0000, 1'b1);
    push_frame(0, 2, 64'h0000, 1'b1);
    push_frame(1, 2, 64'h0101, 1'b1);
    push_frame(2, 2, 64'h0202, 1'b1);
    push_frame(3, 2, 64'h0303, 1'b1);
    exp_frame(0, 2, 64'h0000, 8'h00);
    exp_frame(1, 2, 64'h0101, 8'h12);
    exp_frame(2, 2, 64'h0202, 8'h24);
    exp_frame(3, 2, 64'h0303, 8'h36);
    exp_frame(0, 2, 64'h0000, 8'h00);
    run_until("t3", 15, 100);
    check("t3_cycles", last_cycles, 20);
    first = -1; zeros = 0; run = 0; maxrun = 0;
    foreach (busy_hist[i]) begin
      if (first < 0) begin
        if (busy_hist[i]) first = i;
      end else if (!busy_hist[i]) begin
        zeros++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("t3_idle_gaps", zeros, 4);
    check("t3_idle_gap_len", maxrun, 1);

    // Back-pressure: m_ready toggles every cycle on requester 1's frame 00 00 -> CRC 00.
    start_test();
    toggle_mode = 1'b1;
    stall_chk   = 1'b1;
    prev_stall  = 1'b0;
    push_frame(1, 2, 64'h0000, 1'b1);
    exp_frame(1, 2, 64'h0000, 8'h00);
    run_until("t4", 3, 30);
    toggle_mode = 1'b0;
    stall_chk   = 1'b0;

    // Overflow: requester 1 sends 6 bytes, truncated at 4; requester 2 is served in between.
    do_reset();
    start_test();
    push_frame(1, 6, 64'h010203040506, 1'b1);
    push_frame(2, 1, 64'h03, 1'b1);
    exp_frame(1, 4, 64'h01020304, 8'hE3);
    exp_frame(2, 1, 64'h03, 8'h09);
    exp_frame(1, 2, 64'h0506, 8'h53);
    run_until("t5", 10, 60);
    check("t5_oflow1_pulses", oflow_cnt[1], 1);
    check("t5_oflow_others", oflow_cnt[0] + oflow_cnt[2] + oflow_cnt[3], 0);

    // Asynchronous reset in the middle of requester 3's frame.
    start_test();
    push_frame(3, 3, 64'h112233, 1'b1);
    tick();
    tick();
    check("t6_pre_byte", out_q.size(), 1);
    @(posedge clk);
    #1;
    drive_inputs();
    check("t6_pre_valid", bus.m_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", bus.m_valid, 1'b0);
    check("t6_rst_m_data", bus.m_data, 8'h00);
    check("t6_rst_req_ready", bus.req_ready, 4'b0000);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_m_src", bus.m_src, 2'd0);
    start_test();
    push_frame(1, 1, 64'h07, 1'b1);
    drive_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_frame(1, 1, 64'h07, 8'h15);
    exp_frame(3, 2, 64'h2233, 8'h1D);
    run_until("t6", 5, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
